// File: rtl/udp_image_tx_sched_pkg.sv
// Shared definitions for the UDP image packet scheduler: one-hot state codes and header layout.
package udp_sched_pkg;

  localparam int unsigned STATE_W = 5;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 5'b00001;
  localparam state_t ST_WAIT_FIFO = 5'b00010;
  localparam state_t ST_START     = 5'b00100;
  localparam state_t ST_SEND      = 5'b01000;
  localparam state_t ST_GAP       = 5'b10000;

  localparam int unsigned HDR_LINE_W  = 16;
  localparam int unsigned HDR_FRAME_W = 16;
  localparam int unsigned UDP_HDR_BYTES = 4;

endpackage

// File: rtl/udp_image_tx_sched_if.sv
// Line-FIFO and transmitter-side signal bundle; master is the scheduler, slave the environment.
interface udp_image_tx_sched_if #(
  parameter int unsigned FIFO_LW = 12
);

  logic [FIFO_LW-1:0] fifo_level;
  logic [31:0]        fifo_rd_data;
  logic               fifo_rd_en;
  logic               tx_start_en;
  logic [15:0]        tx_byte_num;
  logic [31:0]        tx_data;
  logic               tx_req;
  logic               tx_done;

  modport master (
    input  fifo_level,
    input  fifo_rd_data,
    input  tx_req,
    input  tx_done,
    output fifo_rd_en,
    output tx_start_en,
    output tx_byte_num,
    output tx_data
  );

  modport slave (
    output fifo_level,
    output fifo_rd_data,
    output tx_req,
    output tx_done,
    input  fifo_rd_en,
    input  tx_start_en,
    input  tx_byte_num,
    input  tx_data
  );

endinterface

// File: rtl/udp_image_tx_sched.sv
// Frame/packet scheduler for the UDP image transmitter: one line per packet, fixed gap between.
// Define UDP_SCHED_HDR_EN to prefix each packet with a {line_idx, frame_cnt} header word.
module udp_image_tx_sched
  import udp_sched_pkg::*;
#(
  parameter int unsigned PKT_BYTES       = 1280,
  parameter int unsigned LINES_PER_FRAME = 480,
  parameter int unsigned IFG_CYCLES      = 12,
  parameter int unsigned FIFO_LW         = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    frame_start,
  udp_image_tx_sched_if.master    bus,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [15:0] PKT_WORDS = 16'(PKT_BYTES / 4);
  localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);
  localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);

`ifdef UDP_SCHED_HDR_EN
  localparam bit          HDR_EN   = 1'b1;
  localparam logic [15:0] BYTE_NUM = 16'(PKT_BYTES + UDP_HDR_BYTES);
`else
  localparam bit          HDR_EN   = 1'b0;
  localparam logic [15:0] BYTE_NUM = 16'(PKT_BYTES);
`endif

  state_t                   state_q, state_d;
  logic [HDR_FRAME_W-1:0]   frame_cnt_q;
  logic [HDR_LINE_W-1:0]    line_idx_q;
  logic [15:0]              word_cnt_q;
  logic [15:0]              gap_cnt_q;
  logic [15:0]              byte_num_q;
  logic [31:0]              tx_data_q;
  logic                     hdr_pend_q;
  logic                     rd_pend_q;

  logic in_send;
  logic serve_hdr;
  logic serve_fifo;
  logic last_line;
  logic fifo_ok;
  logic [31:0] level_ext;

  assign level_ext  = 32'(bus.fifo_level);
  assign fifo_ok    = level_ext >= 32'(PKT_WORDS);
  assign in_send    = (state_q == ST_SEND);
  assign last_line  = (line_idx_q == LAST_LINE);
  assign serve_hdr  = in_send && bus.tx_req && hdr_pend_q;
  // Requests past the payload (transmitter trailer/padding) are absorbed without a read.
  assign serve_fifo = in_send && bus.tx_req && !hdr_pend_q && (word_cnt_q < PKT_WORDS);

  assign bus.fifo_rd_en  = serve_fifo && !rst;
  assign bus.tx_start_en = (state_q == ST_START);
  assign bus.tx_byte_num = byte_num_q;
  // FIFO data lands one cycle after the strobe, so it is forwarded straight through then held.
  assign bus.tx_data     = rd_pend_q ? bus.fifo_rd_data : tx_data_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = in_send && bus.tx_done && last_line && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enable && frame_start) state_d = ST_WAIT_FIFO;
      ST_WAIT_FIFO: if (fifo_ok) state_d = ST_START;
      ST_START:     state_d = ST_SEND;
      ST_SEND:      if (bus.tx_done) state_d = last_line ? ST_IDLE : ST_GAP;
      ST_GAP:       if (gap_cnt_q == GAP_LAST) state_d = ST_WAIT_FIFO;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      line_idx_q  <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      byte_num_q  <= '0;
      tx_data_q   <= '0;
      hdr_pend_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= serve_fifo;

      if (rd_pend_q) begin
        tx_data_q <= bus.fifo_rd_data;
      end else if (serve_hdr) begin
        tx_data_q <= {line_idx_q, frame_cnt_q};
      end

      if (serve_hdr) hdr_pend_q <= 1'b0;
      if (serve_fifo) word_cnt_q <= word_cnt_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (enable && frame_start) begin
            line_idx_q  <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        ST_WAIT_FIFO: begin
          if (fifo_ok) byte_num_q <= BYTE_NUM;
        end
        ST_START: begin
          word_cnt_q <= '0;
          hdr_pend_q <= HDR_EN;
        end
        ST_SEND: begin
          if (bus.tx_done && !last_line) line_idx_q <= line_idx_q + 16'd1;
        end
        ST_GAP: begin
          gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? 16'd0 : gap_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_image_tx_sched.sv
// Scoreboard bench for udp_image_tx_sched; header expectations follow UDP_SCHED_HDR_EN.
module tb_udp_image_tx_sched;

  localparam int unsigned PKT_BYTES = 16;
  localparam int unsigned LINES     = 3;
  localparam int unsigned IFG       = 4;
  localparam int unsigned FIFO_LW   = 12;
  localparam int unsigned NREQ      = 7;
`ifdef UDP_SCHED_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam logic [15:0] EXP_BYTES = HDR ? 16'd20 : 16'd16;

  logic clk = 1'b0;
  logic rst, enable, frame_start;
  logic busy, frame_done;

  udp_image_tx_sched_if #(.FIFO_LW(FIFO_LW)) bus ();

  udp_image_tx_sched #(
    .PKT_BYTES      (PKT_BYTES),
    .LINES_PER_FRAME(LINES),
    .IFG_CYCLES     (IFG),
    .FIFO_LW        (FIFO_LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_start(frame_start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int rd_base = 0;
  int n_starts = 0;
  int done_cyc = 0;

  logic [15:0] start_q[$];
  logic [31:0] data_q[$];
  int          done_q[$];
  logic        req_d = 1'b0;

  function automatic logic [31:0] fifo_word(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", name);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Line FIFO model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= fifo_word(rd_cnt);
      rd_cnt <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.tx_start_en) begin
      n_starts <= n_starts + 1;
      if (start_q.size() == 0) fail_now("unexpected_tx_start_en");
      else check("tx_byte_num", 32'(bus.tx_byte_num), 32'(start_q.pop_front()));
    end
    if (req_d) begin
      if (data_q.size() == 0) fail_now("unexpected_tx_data");
      else check("tx_data", bus.tx_data, data_q.pop_front());
    end
    req_d <= bus.tx_req;
    if (frame_done) begin
      if (done_q.size() == 0) fail_now("unexpected_frame_done");
      else check("rd_cnt_at_frame_done", 32'(rd_cnt), 32'(done_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int s, output bit busy_ok);
    int n;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!bus.tx_start_en && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!bus.tx_start_en) begin
      $display("FAIL start_timeout: no tx_start_en within %0d cycles", n);
      $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
      $fatal(1, "timeout");
    end
    s = cyc;
  endtask

  task automatic do_packet(input int line, input int frame, input bit last_pkt, input bit poke);
    logic [31:0] e, last;
    int w;
    w = 0;
    last = '0;
    tick();
    for (int k = 0; k < NREQ; k++) begin
      if (HDR && k == 0) e = {16'(line), 16'(frame)};
      else if (w < PKT_BYTES / 4) begin
        e = fifo_word(rd_base + w);
        w++;
      end else e = last;
      last = e;
      data_q.push_back(e);
      bus.tx_req  = 1'b1;
      frame_start = poke && (k == 1);
      tick();
    end
    bus.tx_req  = 1'b0;
    frame_start = 1'b0;
    rd_base += PKT_BYTES / 4;
    tick();
    if (last_pkt) done_q.push_back(rd_base);
    else start_q.push_back(EXP_BYTES);
    bus.tx_done = 1'b1;
    done_cyc = cyc;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic run_frame(input int frame, input int ref_cyc, input int lat, input bit poke);
    int s;
    bit bok;
    for (int p = 0; p < LINES; p++) begin
      wait_start(s, bok);
      if (p == 0) check("first_start_latency", 32'(s - ref_cyc), 32'(lat));
      else begin
        check("done_to_start", 32'(s - done_cyc), 32'(IFG + 2));
        check("busy_in_gap", 32'(bok), 32'd1);
      end
      do_packet(p, frame, p == LINES - 1, poke && p == 0);
    end
    repeat (3) tick();
    check("idle_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start_en"}, 32'(bus.tx_start_en), 32'd0);
    check({tag, "_fifo_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
    check({tag, "_tx_byte_num"}, 32'(bus.tx_byte_num), 32'd0);
    check({tag, "_tx_data"}, bus.tx_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int fs, lvl_cyc, s, starts0;
    bit bok;
    rst = 1'b1;
    enable = 1'b0;
    frame_start = 1'b0;
    bus.tx_req = 1'b0;
    bus.tx_done = 1'b0;
    bus.fifo_level = '0;
    repeat (3) tick();
    @(negedge clk);
    check_outputs_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // Frame 1: FIFO already deep enough, full frame of packets.
    enable = 1'b1;
    bus.fifo_level = 12'd12;
    start_q.push_back(EXP_BYTES);
    frame_start = 1'b1;
    fs = cyc;
    tick();
    frame_start = 1'b0;
    run_frame(1, fs, 2, 1'b0);
    check("rd_cnt_frame1", 32'(rd_cnt), 32'd12);

    // Frame 2: FIFO too shallow holds off the first start; frame_start in SEND is ignored.
    bus.fifo_level = 12'd3;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    starts0 = n_starts;
    repeat (10) tick();
    check("no_start_low_level", 32'(n_starts - starts0), 32'd0);
    check("busy_wait_fifo", 32'(busy), 32'd1);
    start_q.push_back(EXP_BYTES);
    bus.fifo_level = 12'd4;
    lvl_cyc = cyc;
    run_frame(2, lvl_cyc, 1, 1'b1);
    check("rd_cnt_frame2", 32'(rd_cnt), 32'd24);

    // Frame 3 interrupted by reset two words into the first packet.
    bus.fifo_level = 12'd12;
    start_q.push_back(EXP_BYTES);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_start(s, bok);
    tick();
    if (HDR) begin
      data_q.push_back({16'd0, 16'd3});
      bus.tx_req = 1'b1;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      data_q.push_back(fifo_word(rd_base + k));
      bus.tx_req = 1'b1;
      tick();
    end
    bus.tx_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_base += 2;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    repeat (2) tick();
    check("busy_after_stray_done", 32'(busy), 32'd0);
    check("rd_cnt_after_reset", 32'(rd_cnt), 32'(rd_base));

    // Fresh frame after reset restarts at line 0, frame 1.
    start_q.push_back(EXP_BYTES);
    frame_start = 1'b1;
    fs = cyc;
    tick();
    frame_start = 1'b0;
    run_frame(1, fs, 2, 1'b0);

    repeat (4) tick();
    check("start_q_drained", 32'(start_q.size()), 32'd0);
    check("data_q_drained", 32'(data_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
